alu_seq: RTL

Registered, parametrised successor of the combinational datapath ALU. Accepts one operation per valid/ready handshake and returns a registered result with N/Z/C/V flags. Keeps the existing op/cmd encoding and adds BIC/MOV/MVN, an iterative multi-cycle MUL, a sticky architectural flags register, and an error indication. Sits between decode/register-read and writeback in the multi-cycle core.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_seq_mul.sv | 50 +++++
 rtl/alu_seq.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: op/cmd codes, flag bit positions
// and the controller state type.
package alu_pkg;

  localparam logic [1:0] OP_DATA = 2'd0;
  localparam logic [1:0] OP_MEM  = 2'd1;
  localparam logic [1:0] OP_BR   = 2'd2;
  localparam logic [1:0] OP_MUL  = 2'd3;

  localparam logic [5:0] CMD_AND = 6'd0;
  localparam logic [5:0] CMD_XOR = 6'd1;
  localparam logic [5:0] CMD_SUB = 6'd2;
  localparam logic [5:0] CMD_RSB = 6'd3;
  localparam logic [5:0] CMD_ADD = 6'd4;
  localparam logic [5:0] CMD_CMP = 6'd10;
  localparam logic [5:0] CMD_ORR = 6'd12;
  localparam logic [5:0] CMD_MOV = 6'd13;
  localparam logic [5:0] CMD_BIC = 6'd14;
  localparam logic [5:0] CMD_MVN = 6'd15;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result bus of alu_seq. Both sides use valid/ready: a transfer
// happens on a rising edge where valid && ready; the sender holds its payload
// stable while valid && !ready. state is a read-only view of the controller.
interface alu_seq_if #(parameter int WIDTH = 32) ();
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic [5:0]       cmd;
  logic             set_flags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic [3:0]       flags_q;
  logic             err;
  alu_state_t       state;

  modport master (
    output in_valid, a, b, op, cmd, set_flags, out_ready,
    input  in_ready, out_valid, result, flags, flags_q, err, state
  );

  modport slave (
    input  in_valid, a, b, op, cmd, set_flags, out_ready,
    output in_ready, out_valid, result, flags, flags_q, err, state
  );
endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits
// of the product. done is asserted in the last iteration with product valid.
module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_next;

  // product is the accumulator including the bit retired this cycle, so the
  // caller can capture it on the same edge the counter finishes.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign done     = busy && (cnt == CW'(WIDTH - 1));
  assign product  = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, N/Z/C/V flags, a sticky
// architectural flags register and an iterative multiply path.
module alu_seq
  import alu_pkg::*;
#(
  parameter int         WIDTH       = 32,
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);
  alu_state_t       state;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_r;
  logic [3:0]       flags_arch;
  logic             err_q;
  logic             mul_sf;

  logic             accept;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic [3:0]       mul_flags;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sub_ab;
  logic [WIDTH-1:0] sub_ba;
  logic             sa;
  logic             sb;

  logic [WIDTH-1:0] res_c;
  logic             c_c;
  logic             v_c;
  logic             err_c;
  logic [3:0]       flags_c;
  logic             upd_c;

  assign bus.in_ready  = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_r;
  assign bus.flags_q   = flags_arch;
  assign bus.err       = err_q;
  assign bus.state     = state;

  assign sum    = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_ab = bus.a - bus.b;
  assign sub_ba = bus.b - bus.a;
  assign sa     = bus.a[WIDTH-1];
  assign sb     = bus.b[WIDTH-1];

  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    err_c = 1'b0;
    case (bus.op)
      OP_DATA: begin
        case (bus.cmd)
          CMD_AND: res_c = bus.a & bus.b;
          CMD_XOR: res_c = bus.a ^ bus.b;
          CMD_SUB, CMD_CMP: begin
            res_c = sub_ab;
            c_c   = bus.a < bus.b;
            v_c   = (sa != sb) && (sub_ab[WIDTH-1] != sa);
          end
          CMD_RSB: begin
            res_c = sub_ba;
            c_c   = bus.b < bus.a;
            v_c   = (sa != sb) && (sub_ba[WIDTH-1] != sb);
          end
          CMD_ADD: begin
            res_c = sum[WIDTH-1:0];
            c_c   = sum[WIDTH];
            v_c   = (sa == sb) && (sum[WIDTH-1] != sa);
          end
          CMD_ORR: res_c = bus.a | bus.b;
          CMD_MOV: res_c = bus.b;
          CMD_BIC: res_c = bus.a & ~bus.b;
          CMD_MVN: res_c = ~bus.b;
          default: err_c = 1'b1;
        endcase
      end
      // Memory without the U bit passes the base through, i.e. A+0: no carry.
      OP_MEM, OP_BR: begin
        if (bus.op == OP_BR || bus.cmd[3]) begin
          res_c = sum[WIDTH-1:0];
          c_c   = sum[WIDTH];
          v_c   = (sa == sb) && (sum[WIDTH-1] != sa);
        end else begin
          res_c = bus.a;
        end
      end
      default: ;
    endcase
  end

  assign flags_c   = {res_c[WIDTH-1], (res_c == '0), c_c, v_c};
  assign upd_c     = (bus.op == OP_DATA) && (bus.set_flags || bus.cmd == CMD_CMP) && !err_c;
  assign mul_flags = {mul_prod[WIDTH-1], (mul_prod == '0), 2'b00};

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && bus.op == OP_MUL),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_r     <= 4'b0000;
      err_q       <= 1'b0;
      flags_arch  <= FLAGS_RESET;
      mul_sf      <= 1'b0;
    end else begin
      if (bus.out_ready) out_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bus.op == OP_MUL) begin
              state  <= ST_MUL;
              mul_sf <= bus.set_flags;
            end else begin
              result_q    <= res_c;
              flags_r     <= flags_c;
              err_q       <= err_c;
              out_valid_q <= 1'b1;
              if (upd_c) flags_arch <= flags_c;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state       <= ST_IDLE;
            result_q    <= mul_prod;
            flags_r     <= mul_flags;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            if (mul_sf) flags_arch <= mul_flags;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
